or1200_cl_dec_stream: RTL and testbench
=======================================

# or1200_cl_dec_stream

Cache-line refill decryptor that consumes the 128-bit AES pad produced by the cache-line encryption block and applies it to the incoming refill data. It sits between the BIU refill path and the data-cache RAM write port. For each line it buffers refill beats until the pad is available, XORs each 32-bit word with its pad slice, and writes the words to the cache in order. Plain lines bypass the XOR and pass straight through.

## Interface
- WORDS, 4: words per cache line; fixed at 4 (128-bit pad / 32-bit word).
- DW, 32: data word width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- secure_exec  in  1  secure mode; qualifies line_enc.
- line_start  in  1  one-cycle pulse marking the start of a refill line.
- line_enc  in  1  sampled with line_start; line is encrypted when line_enc & secure_exec.
- pad_valid  in  1  one-cycle pulse; pad is valid (the encryption block's done).
- pad  in  128  encryption pad.
- biu_ack_i  in  1  refill beat valid.
- biu_dat_i  in  32  refill beat data; beats arrive in word order 0..3.
- dc_we_o  out  1  cache word write strobe.
- dc_word_o  out  2  word index of dc_dat_o.
- dc_dat_o  out  32  decrypted or plain word.
- line_done_o  out  1  one-cycle pulse coincident with the 4th dc_we_o of a line.
- busy_o  out  1  a line is in progress.
- err_o  out  1  one-cycle protocol-error pulse.

## Operation
- States: IDLE, ENC (encrypted line), PLAIN (bypass line).
- IDLE: on line_start, go to ENC if line_enc & secure_exec, else PLAIN. Clear in_ptr, out_ptr and the buffer valid bits.
- Pad register: pad_valid in any state loads pad_r and sets pad_ok.
  - pad_ok clears when an ENC line completes, and when line_start selects PLAIN.
  - A pad arriving before line_start is therefore kept for the next encrypted line.
- ENC, input side: each biu_ack_i writes biu_dat_i into buf[in_ptr], sets vld[in_ptr] and increments in_ptr.
- ENC, output side: when pad_ok and the word at out_ptr is available, register dc_dat_o = word ^ pad_r[127-32*out_ptr -: 32], dc_word_o = out_ptr, dc_we_o = 1, then increment out_ptr.
  - Available means vld[out_ptr] is set, or biu_ack_i is high this cycle with in_ptr == out_ptr (forwarding).
  - Word 0 uses pad_r[127:96]; word 3 uses pad_r[31:0].
  - At most one word is emitted per cycle.
- PLAIN: each biu_ack_i registers dc_dat_o = biu_dat_i and dc_word_o = in_ptr, with dc_we_o = 1, and increments in_ptr.
- Completion: when the word with index 3 is emitted, line_done_o = 1 in the same cycle. The state returns to IDLE at that edge.
- busy_o = (state != IDLE).
- err_o pulses for one cycle on any of the following; each offending event is ignored:
  - biu_ack_i in IDLE;
  - biu_ack_i after 4 beats of the current line have been accepted;
  - line_start while busy_o = 1.
- pad_valid while pad_ok is already set overwrites pad_r. No error is raised.

## Timing
- Reset (rst = 0): all outputs are 0 and state = IDLE. pad_r, pad_ok, buf, vld and the pointers are cleared.
- Reset asserted mid-line aborts the line with no line_done_o.
- PLAIN: biu_ack_i at cycle n gives dc_we_o at cycle n+1.
- ENC with pad_ok already set: beat at cycle n gives dc_we_o at n+1 (forwarded).
- ENC, pad late: pad_valid at cycle p makes pad_ok set from p+1. The first buffered word is emitted at p+2, and the rest follow one per cycle.
- pad_valid in the same cycle as a beat: the pad is not forwarded. That word is emitted no earlier than 2 cycles later.
- Earliest line_start after line_done_o: the next cycle. line_start in the same cycle as line_done_o raises err_o.
- dc_we_o, line_done_o and err_o are registered single-cycle pulses.

## Test plan
- PLAIN line: secure_exec = 0, line_start, then beats 0x11111111..0x44444444 on consecutive cycles -> four dc_we_o one cycle later with identical data and indices 0..3; line_done_o with index 3; pad_ok cleared.
- ENC, pad first: pad = 0xFFFFFFFF_00000000_AAAAAAAA_12345678, pad_valid in IDLE, line_start with line_enc = 1, beats 0x0F0F0F0F ×4 -> dc_dat_o = 0xF0F0F0F0, 0x0F0F0F0F, 0xA5A5A5A5, 0x1D3B5977, each 1 cycle after its beat.
- ENC, pad late: all 4 beats arrive, pad_valid 10 cycles later -> dc_we_o at p+2..p+5 with words 0..3 in order; busy_o high throughout.
- ENC, pad mid-line: pad_valid in the same cycle as beat 1 -> word 0 and word 1 emitted back-to-back starting 2 cycles later, then words 2 and 3 follow; each word matches the XOR of its data with its pad slice.
- Errors: a 5th beat, a beat in IDLE, and line_start while busy -> one err_o pulse each; dc_* outputs are unaffected.
- Reset mid-ENC after 2 beats -> all outputs 0 immediately; a following PLAIN line completes normally with pad_ok = 0.

Source files
------------

// File: rtl/or1200_cl_dec_stream.sv
// Cache-line refill decryptor: buffers refill beats until the AES pad is present,
// XORs each word with its pad slice and writes words to the data cache in order.
module or1200_cl_dec_stream #(
    parameter int WORDS = 4,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  secure_exec,
    input  logic                  line_start,
    input  logic                  line_enc,
    input  logic                  pad_valid,
    input  logic [WORDS*DW-1:0]   pad,
    input  logic                  biu_ack_i,
    input  logic [DW-1:0]         biu_dat_i,
    output logic                  dc_we_o,
    output logic [1:0]            dc_word_o,
    output logic [DW-1:0]         dc_dat_o,
    output logic                  line_done_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [1:0]            dbg_state,
    output logic                  dbg_pad_ok
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_PLAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          in_ptr, out_ptr;
    logic [DW-1:0]       line_buf [WORDS];
    logic [WORDS-1:0]    vld;
    logic [WORDS*DW-1:0] pad_r;
    logic                pad_ok;
    logic [DW-1:0]       pad_w [WORDS];

    logic                start_ok, start_enc, beat_ok, fwd;
    logic                enc_emit, plain_emit;
    logic [DW-1:0]       enc_word;
    logic                we_d, done_d, err_d;
    logic [1:0]          word_d;
    logic [DW-1:0]       dat_d;

    // Word 0 takes the most significant pad slice.
    generate
        for (genvar i = 0; i < WORDS; i++) begin : g_pad
            assign pad_w[i] = pad_r[(WORDS-1-i)*DW +: DW];
        end
    endgenerate

    // A line_start in the cycle line_done_o is high is still treated as overlapping the line.
    always_comb begin
        start_ok   = line_start && (state_q == S_IDLE) && !line_done_o;
        start_enc  = start_ok && line_enc && secure_exec;
        beat_ok    = biu_ack_i && (state_q != S_IDLE) && !in_ptr[2];
        err_d      = (biu_ack_i && !beat_ok) || (line_start && !start_ok);
        fwd        = beat_ok && (in_ptr == out_ptr);
        enc_word   = vld[out_ptr[1:0]] ? line_buf[out_ptr[1:0]] : biu_dat_i;
        enc_emit   = (state_q == S_ENC) && pad_ok && !out_ptr[2] && (vld[out_ptr[1:0]] || fwd);
        plain_emit = (state_q == S_PLAIN) && beat_ok;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = start_enc ? S_ENC : S_PLAIN;
            S_ENC,
            S_PLAIN: if (done_d) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic (values registered into the dc_* pulses below)
    always_comb begin
        we_d   = enc_emit || plain_emit;
        word_d = enc_emit ? out_ptr[1:0] : in_ptr[1:0];
        dat_d  = enc_emit ? (enc_word ^ pad_w[out_ptr[1:0]]) : biu_dat_i;
        done_d = we_d && (word_d == 2'd3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ptr  <= '0;
            out_ptr <= '0;
            vld     <= '0;
            for (int i = 0; i < WORDS; i++) line_buf[i] <= '0;
        end else if (start_ok) begin
            in_ptr  <= '0;
            out_ptr <= '0;
            vld     <= '0;
        end else begin
            if (beat_ok) begin
                in_ptr <= in_ptr + 3'd1;
                if (state_q == S_ENC) begin
                    line_buf[in_ptr[1:0]] <= biu_dat_i;
                    vld[in_ptr[1:0]]      <= 1'b1;
                end
            end
            if (enc_emit) out_ptr <= out_ptr + 3'd1;
        end
    end

    // A fresh pad wins over a same-cycle clear so it survives for the next line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pad_r  <= '0;
            pad_ok <= 1'b0;
        end else if (pad_valid) begin
            pad_r  <= pad;
            pad_ok <= 1'b1;
        end else if ((enc_emit && done_d) || (start_ok && !start_enc)) begin
            pad_ok <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc_we_o     <= 1'b0;
            dc_word_o   <= '0;
            dc_dat_o    <= '0;
            line_done_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            dc_we_o     <= we_d;
            line_done_o <= done_d;
            err_o       <= err_d;
            if (we_d) begin
                dc_word_o <= word_d;
                dc_dat_o  <= dat_d;
            end
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign dbg_state  = state_q;
    assign dbg_pad_ok = pad_ok;

endmodule

// File: tb/tb_or1200_cl_dec_stream.sv
// Bench for or1200_cl_dec_stream: directed refill scenarios plus random traffic,
// checked cycle by cycle against a line-level reference model.
module tb_or1200_cl_dec_stream;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         secure_exec = 1'b0;
    logic         line_start = 1'b0;
    logic         line_enc = 1'b0;
    logic         pad_valid = 1'b0;
    logic [127:0] pad = '0;
    logic         biu_ack_i = 1'b0;
    logic [31:0]  biu_dat_i = '0;
    logic         dc_we_o;
    logic [1:0]   dc_word_o;
    logic [31:0]  dc_dat_o;
    logic         line_done_o;
    logic         busy_o;
    logic         err_o;
    logic [1:0]   dbg_state;
    logic         dbg_pad_ok;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    // reference model: mode 0 idle, 1 encrypted line, 2 plain line
    logic [1:0]   m_mode;
    logic [31:0]  m_beats[$];
    int           m_emitted;
    logic [127:0] m_pad;
    logic         m_pad_ok;
    logic         e_we, e_done, e_err;
    logic [1:0]   e_word;
    logic [31:0]  e_dat;

    always #5 clk = ~clk;

    or1200_cl_dec_stream dut (
        .clk         (clk),
        .rst         (rst),
        .secure_exec (secure_exec),
        .line_start  (line_start),
        .line_enc    (line_enc),
        .pad_valid   (pad_valid),
        .pad         (pad),
        .biu_ack_i   (biu_ack_i),
        .biu_dat_i   (biu_dat_i),
        .dc_we_o     (dc_we_o),
        .dc_word_o   (dc_word_o),
        .dc_dat_o    (dc_dat_o),
        .line_done_o (line_done_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .dbg_state   (dbg_state),
        .dbg_pad_ok  (dbg_pad_ok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pad_slice(input logic [127:0] p, input int w);
        return 32'(p >> (96 - 32 * w));
    endfunction

    task automatic model_reset();
        m_mode = 2'd0;
        m_beats.delete();
        m_emitted = 0;
        m_pad = '0;
        m_pad_ok = 1'b0;
        e_we = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
        e_word = '0;
        e_dat = '0;
    endtask

    task automatic model_step(input bit ls, input bit le, input bit sec, input bit pv,
                              input logic [127:0] pd, input bit ack, input logic [31:0] d);
        bit prev_done, start, beat, clr;
        prev_done = e_done;
        e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
        start = 0; beat = 0; clr = 0;
        if (ls) begin
            if (m_mode != 2'd0 || prev_done) e_err = 1'b1;
            else start = 1;
        end
        if (ack) begin
            if (m_mode == 2'd0 || m_beats.size() == 4) e_err = 1'b1;
            else beat = 1;
        end
        if (m_mode == 2'd2 && beat) begin
            e_we = 1'b1;
            e_word = 2'(m_beats.size());
            e_dat = d;
        end
        if (m_mode == 2'd1 && m_pad_ok && (m_emitted < m_beats.size() || beat)) begin
            e_we = 1'b1;
            e_word = 2'(m_emitted);
            e_dat = ((m_emitted < m_beats.size()) ? m_beats[m_emitted] : d) ^ pad_slice(m_pad, m_emitted);
        end
        if (beat) m_beats.push_back(d);
        if (e_we) begin
            m_emitted++;
            if (e_word == 2'd3) begin
                e_done = 1'b1;
                if (m_mode == 2'd1) clr = 1;
                m_mode = 2'd0;
            end
        end
        if (start) begin
            m_mode = (le && sec) ? 2'd1 : 2'd2;
            m_beats.delete();
            m_emitted = 0;
            if (!(le && sec)) clr = 1;
        end
        if (pv) begin
            m_pad = pd;
            m_pad_ok = 1'b1;
        end else if (clr) begin
            m_pad_ok = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        check("we", 32'(dc_we_o), 32'(e_we));
        check("done", 32'(line_done_o), 32'(e_done));
        check("err", 32'(err_o), 32'(e_err));
        check("busy", 32'(busy_o), 32'(m_mode != 2'd0));
        check("state", 32'(dbg_state), 32'(m_mode));
        check("pad_ok", 32'(dbg_pad_ok), 32'(m_pad_ok));
        if (e_we) begin
            check("word", 32'(dc_word_o), 32'(e_word));
            check("dat", dc_dat_o, e_dat);
        end
        if (dc_we_o && exp_q.size() > 0) check("sb_dat", dc_dat_o, exp_q.pop_front());
    endtask

    task automatic step(input bit ls, input bit le, input bit sec, input bit pv,
                        input logic [127:0] pd, input bit ack, input logic [31:0] d);
        line_start = ls; line_enc = le; secure_exec = sec;
        pad_valid = pv; pad = pd; biu_ack_i = ack; biu_dat_i = d;
        model_step(ls, le, sec, pv, pd, ack, d);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, '0);
    endtask

    task automatic beat(input logic [31:0] d);
        step(0, 0, 0, 0, '0, 1, d);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        line_start = 0; line_enc = 0; secure_exec = 0;
        pad_valid = 0; pad = '0; biu_ack_i = 0; biu_dat_i = '0;
        #1;
        check("rst_we", 32'(dc_we_o), 32'd0);
        check("rst_word", 32'(dc_word_o), 32'd0);
        check("rst_dat", dc_dat_o, 32'd0);
        check("rst_done", 32'(line_done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_pad_ok", 32'(dbg_pad_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [127:0] p;
        logic [31:0]  b [4];
        model_reset();
        do_reset();

        // plain line drops a waiting pad
        step(0, 0, 0, 1, {4{32'hDEADBEEF}}, 0, '0);
        step(1, 0, 0, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            b[i] = 32'h11111111 * (i + 1);
            exp_q.push_back(b[i]);
            beat(b[i]);
        end
        idle(2);
        check("sb_empty_plain", 32'(exp_q.size()), 32'd0);

        // encrypted line, pad present before the line starts
        p = 128'hFFFFFFFF_00000000_AAAAAAAA_12345678;
        step(0, 0, 0, 1, p, 0, '0);
        step(1, 1, 1, 0, '0, 0, '0);
        exp_q.push_back(32'hF0F0F0F0);
        exp_q.push_back(32'h0F0F0F0F);
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h1D3B5977);
        for (int i = 0; i < 4; i++) beat(32'h0F0F0F0F);
        idle(2);
        check("sb_empty_pad_first", 32'(exp_q.size()), 32'd0);

        // encrypted line, pad arrives after all beats
        p = {$urandom, $urandom, $urandom, $urandom};
        step(1, 1, 1, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            b[i] = $urandom;
            exp_q.push_back(b[i] ^ pad_slice(p, i));
            beat(b[i]);
        end
        idle(10);
        step(0, 0, 0, 1, p, 0, '0);
        idle(6);
        check("sb_empty_pad_late", 32'(exp_q.size()), 32'd0);

        // encrypted line, pad arrives together with beat 1
        p = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            b[i] = $urandom;
            exp_q.push_back(b[i] ^ pad_slice(p, i));
        end
        step(1, 1, 1, 0, '0, 0, '0);
        beat(b[0]);
        step(0, 0, 0, 1, p, 1, b[1]);
        beat(b[2]);
        beat(b[3]);
        idle(4);
        check("sb_empty_pad_mid", 32'(exp_q.size()), 32'd0);

        // protocol errors
        step(1, 0, 0, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) beat($urandom);
        step(1, 0, 0, 0, '0, 1, $urandom);   // start and 5th beat during line_done
        beat($urandom);                       // beat in idle
        step(1, 1, 1, 0, '0, 0, '0);
        step(1, 0, 0, 0, '0, 0, '0);          // start while busy
        for (int i = 0; i < 4; i++) beat($urandom);
        beat($urandom);                       // 5th beat while waiting for pad
        step(0, 0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 0, '0);
        idle(6);

        // reset in the middle of an encrypted line
        step(0, 0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 0, '0);
        step(1, 1, 1, 0, '0, 0, '0);
        beat($urandom);
        beat($urandom);
        do_reset();
        step(1, 0, 1, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) beat($urandom);
        idle(2);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 1) == 1, $urandom);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
